// File: rtl/disparity_wta_pkg.sv
// disparity_wta_pkg: shared census/WTA constants
package disparity_wta_pkg;
  localparam int CENSUS_BITS = 32;
  localparam int COST_W = $clog2(CENSUS_BITS + 1);
  localparam int NUM_DISP_DEF = 16;
  localparam int DISP_W_DEF = 4;
  localparam int UNIQ_THRESH_DEF = 2;
  localparam logic [COST_W-1:0] MAX_COST = '1;
endpackage

// File: rtl/disparity_wta_if.sv
// disparity_wta_if: cost stream in, per-pixel WTA result out
interface disparity_wta_if
  import disparity_wta_pkg::*;
#(
  parameter int COST_WIDTH = COST_W,
  parameter int DISP_WIDTH = DISP_W_DEF
);
  logic                  cost_valid;
  logic [COST_WIDTH-1:0] cost;
  logic                  out_valid;
  logic [DISP_WIDTH-1:0] out_disp;
  logic [COST_WIDTH-1:0] out_cost;
  logic                  out_confident;
  modport master (output cost_valid, cost, input out_valid, out_disp, out_cost, out_confident);
  modport slave (input cost_valid, cost, output out_valid, out_disp, out_cost, out_confident);
endinterface

// File: rtl/disparity_wta_compare_step.sv
// wta_compare_step: one best/second/argmin update for a new cost
module wta_compare_step
  import disparity_wta_pkg::*;
#(
  parameter int COST_WIDTH = COST_W,
  parameter int DISP_WIDTH = DISP_W_DEF
) (
  input  logic [COST_WIDTH-1:0] i_best,
  input  logic [COST_WIDTH-1:0] i_second,
  input  logic [DISP_WIDTH-1:0] i_best_idx,
  input  logic [COST_WIDTH-1:0] i_cost,
  input  logic [DISP_WIDTH-1:0] i_d,
  input  logic                  i_first,
  output logic [COST_WIDTH-1:0] o_best,
  output logic [COST_WIDTH-1:0] o_second,
  output logic [DISP_WIDTH-1:0] o_best_idx
);
  logic w_lt_best, w_lt_second;
  // strict compares keep the lower disparity on ties; an equal cost still lowers second
  always_comb begin
    w_lt_best   = i_cost < i_best;
    w_lt_second = i_cost < i_second;
    o_best      = (i_first || w_lt_best) ? i_cost : i_best;
    o_second    = i_first ? '1 : w_lt_best ? i_best : w_lt_second ? i_cost : i_second;
    o_best_idx  = i_first ? '0 : w_lt_best ? i_d : i_best_idx;
  end
endmodule

// File: rtl/disparity_wta.sv
// disparity_wta: winner-take-all disparity selector with uniqueness flag
module disparity_wta
  import disparity_wta_pkg::*;
#(
  parameter int COST_WIDTH  = COST_W,
  parameter int NUM_DISP    = NUM_DISP_DEF,
  parameter int DISP_WIDTH  = DISP_W_DEF,
  parameter int UNIQ_THRESH = UNIQ_THRESH_DEF
) (
  input logic clk,
  input logic rst,
  disparity_wta_if.slave bus
);
  localparam logic [DISP_WIDTH-1:0] LAST = DISP_WIDTH'(NUM_DISP - 1);
  localparam logic [COST_WIDTH-1:0] THRESH = COST_WIDTH'(UNIQ_THRESH);
  logic [DISP_WIDTH-1:0] r_d, r_best_idx, r_out_disp, w_best_idx;
  logic [COST_WIDTH-1:0] r_best, r_second, r_out_cost, w_best, w_second;
  logic                  r_out_valid, r_out_confident, w_last;
  assign w_last = r_d == LAST;
  wta_compare_step #(.COST_WIDTH(COST_WIDTH), .DISP_WIDTH(DISP_WIDTH)) u_step (
    .i_best(r_best), .i_second(r_second), .i_best_idx(r_best_idx), .i_cost(bus.cost),
    .i_d(r_d), .i_first(r_d == '0),
    .o_best(w_best), .o_second(w_second), .o_best_idx(w_best_idx)
  );
  // accept costs, track running best/second, and latch the result on the last disparity
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d             <= '0;
      r_best          <= '0;
      r_second        <= '1;
      r_best_idx      <= '0;
      r_out_valid     <= 1'b0;
      r_out_disp      <= '0;
      r_out_cost      <= '0;
      r_out_confident <= 1'b0;
    end else begin
      r_out_valid <= bus.cost_valid && w_last;
      if (bus.cost_valid) begin
        r_d        <= w_last ? '0 : r_d + 1'b1;
        r_best     <= w_best;
        r_second   <= w_second;
        r_best_idx <= w_best_idx;
        if (w_last) begin
          r_out_disp      <= w_best_idx;
          r_out_cost      <= w_best;
          r_out_confident <= (w_second - w_best) >= THRESH;
        end
      end
    end
  end
  assign bus.out_valid     = r_out_valid;
  assign bus.out_disp      = r_out_disp;
  assign bus.out_cost      = r_out_cost;
  assign bus.out_confident = r_out_confident;
endmodule

// File: tb/tb_disparity_wta.sv
// tb_disparity_wta: scoreboard bench for disparity_wta at NUM_DISP=4
module tb_disparity_wta;
  localparam int ND = 4;
  typedef struct {
    logic [3:0] disp;
    logic [5:0] cost;
    logic       conf;
    int         cyc;
  } exp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, n_vec = 0, n_err = 0;
  exp_t sb[$];
  logic [5:0] pix[$];
  exp_t hand;
  bit use_hand = 0;
  disparity_wta_if #(.COST_WIDTH(6), .DISP_WIDTH(4)) bus ();
  disparity_wta #(.COST_WIDTH(6), .NUM_DISP(ND), .DISP_WIDTH(4), .UNIQ_THRESH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(input logic [5:0] p[$]);
    exp_t e;
    logic [5:0] best, second;
    int idx;
    best = p[0];
    idx = 0;
    for (int i = 1; i < p.size(); i++) if (p[i] < best) begin best = p[i]; idx = i; end
    second = 6'h3f;
    for (int i = 0; i < p.size(); i++) if (i != idx && p[i] < second) second = p[i];
    e.disp = 4'(idx);
    e.cost = best;
    e.conf = (second - best) >= 6'd2;
    e.cyc = 0;
    return e;
  endfunction
  task automatic send(input logic [5:0] c);
    exp_t e;
    @(posedge clk); #1;
    bus.cost_valid = 1;
    bus.cost = c;
    pix.push_back(c);
    if (pix.size() == ND) begin
      e = use_hand ? hand : model(pix);
      e.cyc = cyc + 1;
      sb.push_back(e);
      pix.delete();
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.cost_valid = 0;
      bus.cost = 6'($urandom);
    end
  endtask
  task automatic check_cleared(input string name);
    n_vec++;
    if (bus.out_valid !== 0 || bus.out_disp !== 0 || bus.out_cost !== 0 || bus.out_confident !== 0) begin
      n_err++;
      $display("FAIL %s: got v=%0b d=%0d c=%0d conf=%0b, want all zero", name,
               bus.out_valid, bus.out_disp, bus.out_cost, bus.out_confident);
    end
  endtask
  task automatic set_hand(input logic [3:0] d, input logic [5:0] c, input logic cf);
    hand.disp = d;
    hand.cost = c;
    hand.conf = cf;
    use_hand = 1;
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: out_valid at cycle %0d with d=%0d c=%0d, none required", cyc, bus.out_disp, bus.out_cost);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.out_disp !== e.disp || bus.out_cost !== e.cost || bus.out_confident !== e.conf || cyc != e.cyc) begin
          n_err++;
          $display("FAIL result: got d=%0d c=%0d conf=%0b cyc=%0d, want d=%0d c=%0d conf=%0b cyc=%0d",
                   bus.out_disp, bus.out_cost, bus.out_confident, cyc, e.disp, e.cost, e.conf, e.cyc);
        end
      end
    end
  end
  initial begin
    bus.cost_valid = 0;
    bus.cost = 0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset_state");
    rst = 0;
    set_hand(4'd1, 6'd3, 1'b1);
    send(9); send(3); send(7); send(5);
    use_hand = 0;
    idle(2);
    set_hand(4'd0, 6'd4, 1'b0);
    send(4); send(4); send(8); send(8);
    use_hand = 0;
    idle(2);
    set_hand(4'd3, 6'd1, 1'b0);
    send(6); idle(2); send(2); idle(1); send(6); send(1);
    use_hand = 0;
    idle(3);
    send(1); send(1);
    @(posedge clk); #1;
    rst = 1;
    bus.cost_valid = 1;
    bus.cost = 0;
    pix.delete();
    @(posedge clk); #1;
    check_cleared("mid_pixel_reset");
    rst = 0;
    bus.cost_valid = 0;
    set_hand(4'd3, 6'd6, 1'b0);
    send(9); send(8); send(7); send(6);
    use_hand = 0;
    idle(2);
    set_hand(4'd2, 6'd0, 1'b1);
    send(5); send(9); send(0); send(2);
    set_hand(4'd3, 6'd60, 1'b0);
    send(63); send(62); send(61); send(60);
    set_hand(4'd0, 6'd10, 1'b1);
    send(10); send(20); send(30); send(12);
    use_hand = 0;
    idle(2);
    set_hand(4'd0, 6'd63, 1'b0);
    send(63); send(63); send(63); send(63);
    use_hand = 0;
    for (int p = 0; p < 400; p++) begin
      for (int k = 0; k < ND; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(p[0] ? 6'($urandom_range(0, 5)) : 6'($urandom));
      end
    end
    idle(4);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results still pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
